// File: rtl/kp_scan.sv
// 4x4 keypad scanner: walks a one-cold column drive, debounces a single-row
// press and release on sample ticks, and reports the key as {rows, cols}.
module kp_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

  logic [3:0]       rs_meta_q, rs_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q;
  logic [3:0]       kpc_q;
  logic [7:0]       code_q;
  logic             valid_q, held_q;
  logic             one_low, row_idle;
  logic [3:0]       kpc_next;

  function automatic logic single_low(input logic [3:0] r);
    case (r)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  // Rows are asynchronous to clk; only rs_q is ever looked at.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rs_meta_q <= 4'hF;
      rs_q      <= 4'hF;
    end else begin
      rs_meta_q <= kpr;
      rs_q      <= rs_meta_q;
    end
  end

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_d;
  end

  assign tick     = (div_q == DIV_LAST);
  assign one_low  = single_low(rs_q);
  assign row_idle = (rs_q == 4'hF);
  assign cnt_d    = cnt_q + CNT_ONE;
  assign kpc_next = {kpc_q[0], kpc_q[3:1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      cand_q  <= 4'hF;
      kpc_q   <= 4'b0111;
      code_q  <= 8'hFF;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (one_low) begin
              cand_q <= rs_q;
              cnt_q  <= CNT_ONE;
              // A single-tick debounce accepts on the capture tick itself.
              if (DEBOUNCE == 1) begin
                code_q  <= {rs_q, kpc_q};
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                state_q <= HELD;
              end else begin
                state_q <= PRESS_DB;
              end
            end else begin
              kpc_q <= kpc_next;
            end
          end
          PRESS_DB: begin
            if (rs_q == cand_q) begin
              cnt_q <= cnt_d;
              if (cnt_d == CNT_DONE) begin
                code_q  <= {cand_q, kpc_q};
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                state_q <= HELD;
              end
            end else begin
              state_q <= SCAN;
            end
          end
          HELD: begin
            if (row_idle) begin
              cnt_q <= CNT_ONE;
              if (DEBOUNCE == 1) begin
                held_q  <= 1'b0;
                kpc_q   <= kpc_next;
                state_q <= SCAN;
              end else begin
                state_q <= REL_DB;
              end
            end
          end
          REL_DB: begin
            if (row_idle) begin
              cnt_q <= cnt_d;
              if (cnt_d == CNT_DONE) begin
                held_q  <= 1'b0;
                kpc_q   <= kpc_next;
                state_q <= SCAN;
              end
            end else begin
              state_q <= HELD;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign kpc       = kpc_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
